fetch_unit: RTL and testbench

// - Fetch-stage producer feeding the F/D pipeline register: owns the PC, issues instruction

---
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch unit (master) and the memory (slave).
interface fetch_unit_if #(
    parameter int SIZE = 32
);
    // imem_req is a single-cycle pulse carrying imem_addr; the slave answers each request
    // exactly once, one or more cycles later, with a one-cycle imem_rvalid pulse and imem_rdata.
    // No back-pressure exists: the master never has more than one request outstanding.
    logic            imem_req;
    logic [SIZE-1:0] imem_addr;
    logic            imem_rvalid;
    logic [SIZE-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues imem reads, buffers returned words for decode.
// Define FETCH_BYPASS_EN to forward a returning word straight to InstrF when the buffer is empty.
module fetch_unit #(
    parameter int              SIZE      = 32,
    parameter logic [SIZE-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            StallF,
    input  logic            PCSrcE,
    input  logic [SIZE-1:0] PCTargetE,
    fetch_unit_if.master    imem,
    output logic [SIZE-1:0] InstrF,
    output logic [SIZE-1:0] PCF,
    output logic [SIZE-1:0] PCPlus4F,
    output logic            InstrValidF,
    output logic [1:0]      dbg_state
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [SIZE-1:0] NOP     = SIZE'(32'h0000_0013);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]      state, state_next;
    logic [SIZE-1:0] fetch_pc;
    logic [SIZE-1:0] next_pcf;
    logic [SIZE-1:0] pc_mem    [BUF_DEPTH];
    logic [SIZE-1:0] instr_mem [BUF_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;

    logic            buf_empty;
    logic            in_flight;
    logic            issue_ok;
    logic            accept;
    logic            byp;
    logic            head_valid;
    logic            consume;
    logic            pop_buf;
    logic            push;
    logic            busy_after;
    logic [SIZE-1:0] target_aligned;

    assign buf_empty      = (count == '0);
    assign in_flight      = (state == S_WAIT) || (state == S_DROP);
    assign issue_ok       = (count + CW'(in_flight)) < DEPTH_C;
    assign accept         = (state == S_WAIT) && imem.imem_rvalid && !PCSrcE;
    assign target_aligned = PCTargetE & ~SIZE'(3);

`ifdef FETCH_BYPASS_EN
    assign byp = buf_empty && accept;
`else
    assign byp = 1'b0;
`endif

    assign head_valid = !buf_empty || byp;
    assign consume    = head_valid && !StallF && !PCSrcE;
    assign pop_buf    = consume && !buf_empty;
    // A bypassed word that decode takes this cycle never occupies a slot.
    assign push       = accept && !(byp && consume);
    assign count_next = count + CW'(push) - CW'(pop_buf);

    assign imem.imem_req  = (state == S_REQ) && issue_ok;
    assign imem.imem_addr = fetch_pc;

    always_comb begin
        InstrF = NOP;
        PCF    = next_pcf;
        if (!buf_empty) begin
            InstrF = instr_mem[rd_ptr];
            PCF    = pc_mem[rd_ptr];
        end else if (byp) begin
            InstrF = imem.imem_rdata;
            PCF    = fetch_pc;
        end
    end

    assign InstrValidF = head_valid;
    assign PCPlus4F    = PCF + SIZE'(4);
    assign dbg_state   = state;

    // A request is still outstanding after this edge if one issues now, or if the
    // current one has not returned yet.
    assign busy_after = imem.imem_req || (in_flight && !imem.imem_rvalid);

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (count_next < DEPTH_C) state_next = S_REQ;
            S_REQ:  state_next = issue_ok ? S_WAIT : S_IDLE;
            S_WAIT: if (imem.imem_rvalid) state_next = (count_next < DEPTH_C) ? S_REQ : S_IDLE;
            S_DROP: if (imem.imem_rvalid) state_next = S_REQ;
            default: state_next = S_IDLE;
        endcase
        if (PCSrcE) state_next = busy_after ? S_DROP : S_REQ;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            next_pcf <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_next;
            if (PCSrcE) begin
                fetch_pc <= target_aligned;
                next_pcf <= target_aligned;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + SIZE'(4);
                if (consume) next_pcf <= PCF + SIZE'(4);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop_buf) rd_ptr <= rd_ptr + PW'(1);
                count <= count_next;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem.imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: imem responder with a fetch-address model and a
// scoreboard of {PC, instruction} words that decode is expected to consume in order.
module tb_fetch_unit;
    localparam int          SIZE      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          BUF_DEPTH = 2;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StallF;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        InstrValidF;
    logic [1:0]  dbg_state;

    always #5 CLK = ~CLK;

    fetch_unit_if #(.SIZE(SIZE)) imem ();

    fetch_unit #(.SIZE(SIZE), .RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .imem(imem.master), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .InstrValidF(InstrValidF), .dbg_state(dbg_state)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    int          lat = 1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    logic        pend_stale = 1'b0;
    logic [31:0] exp_fetch = RESET_PC;
    logic        ok;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory responder and expected-stream producer; drives rvalid at negedges.
    always @(negedge CLK) begin
        if (!RST_N) begin
            if (pend > 0) pend_stale = 1'b1;
            exp_q.delete();
            exp_fetch = RESET_PC;
        end
        imem.imem_rvalid = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata  = mem_word(pend_addr);
                if (!pend_stale && !PCSrcE && RST_N) begin
                    exp_q.push_back({pend_addr, mem_word(pend_addr)});
                    exp_fetch = pend_addr + 32'd4;
                end
            end
        end
        if (imem.imem_req && RST_N) begin
            chk("imem_addr", imem.imem_addr, exp_fetch);
            pend_addr  = exp_fetch;
            pend       = lat;
            pend_stale = PCSrcE;
        end
        if (PCSrcE && RST_N) begin
            exp_q.delete();
            if (pend > 0) pend_stale = 1'b1;
            exp_fetch = PCTargetE & ~32'd3;
        end
    end

    // Scoreboard consumer: every word decode takes must be the next expected one.
    always @(negedge CLK) begin
        logic [63:0] e;
        #1;
        if (RST_N && InstrValidF && !StallF && !PCSrcE) begin
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed_pc=%h expected=none", PCF);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_pc", PCF, e[63:32]);
                chk("sb_instr", InstrF, e[31:0]);
                chk("sb_pc4", PCPlus4F, e[63:32] + 32'd4);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic smp;
        @(negedge CLK);
        #2;
    endtask

    task automatic wait_req(output logic found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            smp();
            if (imem.imem_req) found = 1'b1;
        end
        chk("wait_req_timeout", {31'd0, found}, 32'd1);
    endtask

    task automatic wait_valid(output logic found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            smp();
            if (InstrValidF) found = 1'b1;
        end
        chk("wait_valid_timeout", {31'd0, found}, 32'd1);
    endtask

    initial begin
        RST_N = 1'b0; StallF = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
        cyc(2);
        smp();
        chk("rst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_pcf", PCF, RESET_PC);
        chk("rst_pc4", PCPlus4F, RESET_PC + 32'd4);
        chk("rst_req", {31'd0, imem.imem_req}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);

        // First fetch after reset, latency 1.
        @(posedge CLK); #1; RST_N = 1'b1;
        wait_req(ok);
        chk("first_addr", imem.imem_addr, RESET_PC);
        cyc();
        smp();
`ifdef FETCH_BYPASS_EN
        chk("lat_rvalid_cycle", {31'd0, InstrValidF}, 32'd1);
        chk("lat_byp_pcf", PCF, RESET_PC);
        chk("lat_byp_instr", InstrF, mem_word(RESET_PC));
`else
        chk("lat_rvalid_cycle", {31'd0, InstrValidF}, 32'd0);
        cyc();
        smp();
        chk("lat_next_cycle", {31'd0, InstrValidF}, 32'd1);
        chk("lat_pcf", PCF, RESET_PC);
`endif
        cyc(12);

        // Hold decode for 5 cycles: buffer fills, requests stop, head stays put.
        wait_valid(ok);
        cyc();
        StallF = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp();
            if (i >= 2) begin
                chk("stall_valid", {31'd0, InstrValidF}, 32'd1);
                chk("stall_pcf", PCF, exp_q[0][63:32]);
                chk("stall_instr", InstrF, exp_q[0][31:0]);
            end
            if (i == 4) chk("stall_no_req", {31'd0, imem.imem_req}, 32'd0);
            cyc();
        end
        StallF = 1'b0;
        cyc(10);

        // Redirect while a slow request is in flight.
        lat = 3;
        wait_req(ok);
        cyc();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0100;
        cyc();
        PCSrcE = 1'b0;
        wait_valid(ok);
        chk("redir_pcf", PCF, 32'h0000_0100);
        chk("redir_instr", InstrF, mem_word(32'h0000_0100));
        cyc(10);

        // Misaligned target is forced to a word boundary.
        lat = 1;
        cyc(3);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
        cyc();
        PCSrcE = 1'b0;
        wait_req(ok);
        chk("align_addr", imem.imem_addr, 32'h0000_0100);
        wait_valid(ok);
        chk("align_pcf", PCF, 32'h0000_0100);
        cyc(6);

        // Redirect with a full buffer under stall: flush wins over StallF.
        StallF = 1'b1;
        cyc(6);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200;
        cyc();
        PCSrcE = 1'b0; StallF = 1'b0;
        wait_valid(ok);
        chk("flush_pcf", PCF, 32'h0000_0200);
        cyc(6);

        // PC wraps past the top of the address space.
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFF8;
        cyc();
        PCSrcE = 1'b0;
        wait_valid(ok);
        chk("wrap_pcf", PCF, 32'hFFFF_FFF8);
        cyc(14);

        // Reset in the middle of a wait; the late response must be ignored.
        lat = 3;
        wait_req(ok);
        cyc();
        RST_N = 1'b0;
        smp();
        chk("midrst_valid", {31'd0, InstrValidF}, 32'd0);
        chk("midrst_state", {30'd0, dbg_state}, 32'd0);
        cyc();
        RST_N = 1'b1;
        smp();
        chk("postrst_valid", {31'd0, InstrValidF}, 32'd0);
        wait_req(ok);
        chk("postrst_addr", imem.imem_addr, RESET_PC);
        lat = 1;
        cyc(12);

        // Random latency, stalls and redirects.
        for (int i = 0; i < 200; i++) begin
            lat    = $urandom_range(1, 3);
            StallF = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) begin
                PCSrcE    = 1'b1;
                PCTargetE = $urandom;
            end else begin
                PCSrcE = 1'b0;
            end
            cyc();
        end
        StallF = 1'b0; PCSrcE = 1'b0; lat = 1;
        cyc(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
